// File: rtl/mips_main_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller: states, opcodes,
// ALU/PC select codes and the packed control vector.
package mips_ctrl_defs;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_REG    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       reg_dst;
    logic       memto_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

endpackage

// File: rtl/mips_main_controller_if.sv
// Controller <-> datapath/memory bundle. master = controller, slave = datapath.
interface mips_main_controller_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       MemWrite, IRWrite, RegWrite, PCWrite, Branch;
  logic       IorD, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       pc_en;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, MemWrite, IRWrite, RegWrite, PCWrite, Branch,
           IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
           pc_en, illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, MemWrite, IRWrite, RegWrite, PCWrite, Branch,
           IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
           pc_en, illegal_op, state
  );
endinterface

// File: rtl/mc_output_decode.sv
// Moore decode of FSM state into the datapath control vector. Only the FETCH
// IR/PC strobes look at mem_ready, so they fire once on the accepting cycle.
module mc_output_decode
  import mips_ctrl_defs::*;
(
  input  state_e state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = ALUB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = ALUB_IMMSH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.memto_reg = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_REG;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
        ctrl.pc_src    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_main_controller.sv
// Multi-cycle MIPS main control FSM. Define MC_ADDI_EN to execute addi;
// otherwise opcode 001000 takes the illegal-opcode path.
module mips_main_controller
  import mips_ctrl_defs::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  mips_main_controller_if.master  bus
);

  state_e     st;
  logic [5:0] op_q;
  logic       illegal_q;
  ctrl_t      ctrl;

  // Memory states stall on mem_ready; all other states advance unconditionally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st        <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (st)
        S_FETCH:  if (bus.mem_ready) st <= S_DECODE;
        S_DECODE: begin
          op_q <= bus.opcode;
          case (bus.opcode)
            OP_LW, OP_SW: st <= S_MEMADR;
            OP_RTYPE:     st <= S_EXEC;
            OP_BEQ:       st <= S_BRANCH;
            OP_J:         st <= S_JUMP;
`ifdef MC_ADDI_EN
            OP_ADDI:      st <= S_ADDIEX;
`else
            OP_ADDI: begin
              st        <= S_FETCH;
              illegal_q <= 1'b1;
            end
`endif
            default: begin
              st        <= S_FETCH;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_MEMADR: st <= (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (bus.mem_ready) st <= S_MEMWB;
        S_MEMWR:  if (bus.mem_ready) st <= S_FETCH;
        S_EXEC:   st <= S_ALUWB;
        S_ADDIEX: st <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: st <= S_FETCH;
        default:  st <= S_FETCH;
      endcase
    end
  end

  mc_output_decode u_dec (
    .state     (st),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.mem_req    = ctrl.mem_req;
  assign bus.MemWrite   = ctrl.mem_write;
  assign bus.IRWrite    = ctrl.ir_write;
  assign bus.RegWrite   = ctrl.reg_write;
  assign bus.PCWrite    = ctrl.pc_write;
  assign bus.Branch     = ctrl.branch;
  assign bus.IorD       = ctrl.iord;
  assign bus.RegDst     = ctrl.reg_dst;
  assign bus.MemtoReg   = ctrl.memto_reg;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.ALUOp      = ctrl.alu_op;
  assign bus.PCSrc      = ctrl.pc_src;
  assign bus.pc_en      = ctrl.pc_write | (ctrl.branch & bus.zero);
  assign bus.illegal_op = illegal_q;
  assign bus.state      = st;

endmodule

// File: tb/tb_mips_main_controller.sv
// Self-checking bench for mips_main_controller: per-opcode state paths and
// per-state control values come from a table model, with random waits.
module tb_mips_main_controller;
  import mips_ctrl_defs::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mips_main_controller_if bus ();

  mips_main_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  bit pend_ill = 1'b0;

  typedef logic [3:0] path_t[$];

  typedef struct packed {
    logic       mem_req, mw, irw, rw, pcw, br, iord, rdst, m2r, asa;
    logic [1:0] asb, aop, pcs;
    logic       pc_en;
  } exp_t;

  function automatic bit addi_on();
`ifdef MC_ADDI_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic path_t model_path(input logic [5:0] op);
    path_t p;
    p = {S_FETCH, S_DECODE};
    if (op == 6'b100011)      p = {p, S_MEMADR, S_MEMRD, S_MEMWB};
    else if (op == 6'b101011) p = {p, S_MEMADR, S_MEMWR};
    else if (op == 6'b000000) p = {p, S_EXEC, S_ALUWB};
    else if (op == 6'b000100) p = {p, S_BRANCH};
    else if (op == 6'b000010) p = {p, S_JUMP};
    else if (op == 6'b001000 && addi_on()) p = {p, S_ADDIEX, S_ADDIWB};
    return p;
  endfunction

  function automatic bit model_illegal(input logic [5:0] op);
    if (op == 6'b001000) return !addi_on();
    return !(op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
             op == 6'b000100 || op == 6'b000010);
  endfunction

  // Zero-wait cycle counts for each instruction class.
  function automatic int min_cycles(input logic [5:0] op);
    case (op)
      6'b100011:                    return 5;
      6'b101011, 6'b000000:         return 4;
      6'b001000:                    return addi_on() ? 4 : 2;
      6'b000100, 6'b000010:         return 3;
      default:                      return 2;
    endcase
  endfunction

  function automatic exp_t model_out(input logic [3:0] s, input logic mr, input logic z);
    exp_t e;
    e = '0;
    case (s)
      S_FETCH:  begin e.mem_req = 1; e.asb = 2'b01; e.irw = mr; e.pcw = mr; end
      S_DECODE: e.asb = 2'b11;
      S_MEMADR, S_ADDIEX: begin e.asa = 1; e.asb = 2'b10; end
      S_MEMRD:  begin e.mem_req = 1; e.iord = 1; end
      S_MEMWR:  begin e.mem_req = 1; e.iord = 1; e.mw = 1; end
      S_MEMWB:  begin e.rw = 1; e.m2r = 1; end
      S_EXEC:   begin e.asa = 1; e.aop = 2'b10; end
      S_ALUWB:  begin e.rw = 1; e.rdst = 1; end
      S_ADDIWB: e.rw = 1;
      S_BRANCH: begin e.asa = 1; e.aop = 2'b01; e.br = 1; e.pcs = 2'b01; end
      S_JUMP:   begin e.pcw = 1; e.pcs = 2'b10; end
      default:  e = '0;
    endcase
    e.pc_en = e.pcw | (e.br & z);
    return e;
  endfunction

  // Drives one instruction through the DUT, comparing every cycle with the model.
  task automatic run_instr(input logic [5:0] op, input logic z, input int wf, input int wm,
                           output int mw_cnt, output int pe_cnt, output int rw_cnt,
                           output int ill_cnt);
    path_t      p;
    logic [3:0] s;
    exp_t       e, act;
    int         nw, cyc, want_cyc;
    bit         first, ismem;
    p = model_path(op);
    cyc = 0; first = 1'b1;
    mw_cnt = 0; pe_cnt = 0; rw_cnt = 0; ill_cnt = 0;
    foreach (p[i]) begin
      s = p[i];
      ismem = (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
      nw = (s == S_FETCH) ? wf : ((s == S_MEMRD || s == S_MEMWR) ? wm : 0);
      for (int k = 0; k <= nw; k++) begin
        bus.mem_ready = ismem ? (k == nw) : 1'($urandom);
        bus.zero      = z;
        bus.opcode    = (s == S_DECODE) ? op : 6'($urandom);
        @(negedge clk);
        e = model_out(s, bus.mem_ready, z);
        act = {bus.mem_req, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.PCWrite,
               bus.Branch, bus.IorD, bus.RegDst, bus.MemtoReg, bus.ALUSrcA,
               bus.ALUSrcB, bus.ALUOp, bus.PCSrc, bus.pc_en};
        total++;
        if (bus.state !== s) begin
          bad++;
          $display("FAIL state op=%b cyc=%0d got=%0d want=%0d", op, cyc, bus.state, s);
        end
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL ctrl op=%b st=%0d cyc=%0d got=%h want=%h", op, s, cyc, act, e);
        end
        total++;
        if (bus.illegal_op !== (first && pend_ill)) begin
          bad++;
          $display("FAIL illegal_op op=%b cyc=%0d got=%b want=%b", op, cyc, bus.illegal_op,
                   first && pend_ill);
        end
        mw_cnt  += int'(bus.MemWrite === 1'b1);
        pe_cnt  += int'(bus.pc_en === 1'b1);
        rw_cnt  += int'(bus.RegWrite === 1'b1);
        ill_cnt += int'(bus.illegal_op === 1'b1);
        first = 1'b0;
        cyc++;
        @(posedge clk); #1;
      end
    end
    want_cyc = min_cycles(op) + wf + ((op == 6'b100011 || op == 6'b101011) ? wm : 0);
    total++;
    if (cyc != want_cyc) begin
      bad++;
      $display("FAIL cpi op=%b got=%0d want=%0d", op, cyc, want_cyc);
    end
    pend_ill = model_illegal(op);
  endtask

  task automatic test_reset();
    bit seen_wr;
    bus.mem_ready = 1'b0; bus.zero = 1'b0; bus.opcode = 6'b0;
    #1;
    total++;
    if (bus.state !== 4'd0 || bus.illegal_op !== 1'b0 || bus.IRWrite !== 1'b0 ||
        bus.mem_req !== 1'b1) begin
      bad++;
      $display("FAIL reset_state got st=%0d ill=%b irw=%b req=%b want 0/0/0/1",
               bus.state, bus.illegal_op, bus.IRWrite, bus.mem_req);
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.opcode = 6'b100011;
    @(posedge clk); #1;
    bus.opcode = 6'b0;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (bus.state !== 4'd3) begin
      bad++;
      $display("FAIL reach_memrd got=%0d want=3", bus.state);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (bus.state !== 4'd0 || bus.RegWrite !== 1'b0) begin
      bad++;
      $display("FAIL reset_async got st=%0d rw=%b want st=0 rw=0", bus.state, bus.RegWrite);
    end
    bus.mem_ready = 1'b1;
    seen_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.RegWrite !== 1'b0 || bus.MemWrite !== 1'b0) seen_wr = 1'b1;
    end
    total++;
    if (seen_wr) begin
      bad++;
      $display("FAIL reset_no_write got write strobe during reset want none");
    end
    #1 reset_n = 1'b1;
    #1;
    total++;
    if (bus.IRWrite !== 1'b1 || bus.state !== 4'd0) begin
      bad++;
      $display("FAIL release_irwrite got irw=%b st=%0d want irw=1 st=0", bus.IRWrite, bus.state);
    end
    @(posedge clk); #1;
    total++;
    if (bus.state !== 4'd1) begin
      bad++;
      $display("FAIL release_decode got=%0d want=1", bus.state);
    end
    bus.opcode = 6'b000010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pend_ill = 1'b0;
  endtask

  task automatic test_lw();
    int mw, pe, rw, il;
    run_instr(6'b100011, 1'b0, 0, 0, mw, pe, rw, il);
    total++;
    if (rw != 1 || mw != 0) begin
      bad++;
      $display("FAIL lw_strobes got rw=%0d mw=%0d want rw=1 mw=0", rw, mw);
    end
    run_instr(6'b100011, 1'b1, 2, 1, mw, pe, rw, il);
  endtask

  task automatic test_sw_wait();
    int mw, pe, rw, il;
    run_instr(6'b101011, 1'b0, 0, 3, mw, pe, rw, il);
    total++;
    if (mw != 4 || rw != 0) begin
      bad++;
      $display("FAIL sw_hold got mw=%0d rw=%0d want mw=4 rw=0", mw, rw);
    end
  endtask

  task automatic test_beq();
    int mw, pe, rw, il;
    run_instr(6'b000100, 1'b1, 0, 0, mw, pe, rw, il);
    total++;
    if (pe != 2) begin
      bad++;
      $display("FAIL beq_taken pc_en cycles got=%0d want=2", pe);
    end
    run_instr(6'b000100, 1'b0, 0, 0, mw, pe, rw, il);
    total++;
    if (pe != 1) begin
      bad++;
      $display("FAIL beq_not_taken pc_en cycles got=%0d want=1", pe);
    end
  endtask

  task automatic test_rtype();
    int mw, pe, rw, il;
    run_instr(6'b000000, 1'b0, 1, 0, mw, pe, rw, il);
    total++;
    if (rw != 1) begin
      bad++;
      $display("FAIL rtype_regwrite got=%0d want=1", rw);
    end
  endtask

  task automatic test_illegal();
    int mw, pe, rw, il;
    run_instr(6'b111111, 1'b0, 0, 0, mw, pe, rw, il);
    total++;
    if (rw != 0 || mw != 0) begin
      bad++;
      $display("FAIL illegal_nowrite got rw=%0d mw=%0d want 0/0", rw, mw);
    end
    run_instr(6'b000010, 1'b0, 1, 0, mw, pe, rw, il);
    total++;
    if (il != 1) begin
      bad++;
      $display("FAIL illegal_pulse got=%0d want=1", il);
    end
    run_instr(6'b001000, 1'b0, 0, 0, mw, pe, rw, il);
    run_instr(6'b000010, 1'b0, 0, 0, mw, pe, rw, il);
    total++;
    if (il != (addi_on() ? 0 : 1)) begin
      bad++;
      $display("FAIL addi_pulse got=%0d want=%0d", il, addi_on() ? 0 : 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[7];
    logic [5:0] op;
    int mw, pe, rw, il;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b110011};
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(6)];
      if (op == 6'b110011) op = 6'($urandom);
      run_instr(op, 1'($urandom), $urandom_range(2), $urandom_range(3), mw, pe, rw, il);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_rtype();
    test_illegal();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before test end");
    $fatal(1);
  end

endmodule

// File: doc/mips_main_controller.md
# mips_main_controller

Multi-cycle main control FSM for the MIPS core. It sequences the shared datapath (PC, IR, register file, single ALU, unified memory) through fetch, decode, execute, memory and writeback steps. It issues the 2-bit ALUOp consumed by the ALU function decoder. Variable memory latency is absorbed with a ready handshake.

## Interface
- No parameters; encodings come from the shared package.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]; sampled in DECODE only
- zero  in  1  ALU zero flag; used in BRANCH
- mem_ready  in  1  memory has completed the current access
- mem_req  out  1  memory access request; held until mem_ready
- MemWrite, IRWrite, RegWrite, PCWrite, Branch, IorD, RegDst, MemtoReg, ALUSrcA  out  1 each  datapath strobes and selects
- ALUSrcB  out  2  ALU B-operand select: 00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 use funct
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- pc_en  out  1  PCWrite | (Branch & zero)
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, for debug

## Operation
- States and transitions:
  - FETCH -> DECODE
  - DECODE -> MEMADR (lw 100011, sw 101011), EXEC (R-type 000000), BRANCH (beq 000100), ADDIEX (addi 001000), JUMP (j 000010), otherwise FETCH with illegal_op=1
  - MEMADR -> MEMRD (lw) or MEMWR (sw)
  - MEMRD -> MEMWB -> FETCH
  - MEMWR -> FETCH
  - EXEC -> ALUWB -> FETCH
  - ADDIEX -> ADDIWB -> FETCH
  - BRANCH -> FETCH
  - JUMP -> FETCH
- The opcode is latched in DECODE so that MEMADR can choose MEMRD or MEMWR.
- Outputs are Moore, decoded from state only; pc_en additionally uses the combinational zero input.
- Per-state assertions (all other outputs 0):
  - FETCH: mem_req, IorD=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite and PCWrite are asserted only in the cycle where mem_ready=1.
  - DECODE: ALUSrcB=11, ALUOp=00.
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: mem_req, IorD=1.
  - MEMWR: mem_req, IorD=1, MemWrite=1.
  - MEMWB: RegWrite, MemtoReg=1, RegDst=0.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - ALUWB: RegWrite, RegDst=1, MemtoReg=0.
  - ADDIWB: RegWrite, RegDst=0, MemtoReg=0.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSrc=01.
  - JUMP: PCWrite, PCSrc=10.

## Timing
- Reset (async assert, sync release): state=FETCH and illegal_op=0. The FETCH outputs are driven immediately, but IRWrite and PCWrite stay 0 until mem_ready.
- Memory states (FETCH, MEMRD, MEMWR):
  - The FSM holds in the state while mem_ready=0.
  - It advances on the edge where mem_ready=1.
  - mem_req stays high for the whole wait.
  - MemWrite is held during the MEMWR wait; memory commits the write once, on the accepting cycle.
- mem_ready outside a memory state is ignored.
- Minimum cycles per instruction with zero wait:
  - lw 5
  - sw, R-type, addi 4
  - beq, j 3
- Each wait cycle adds 1.
- illegal_op asserts in the cycle after DECODE, together with the return to FETCH.
- Reset mid-instruction abandons it. No RegWrite or MemWrite is issued after reset_n falls.

## Configuration
- MC_ADDI_EN defined: ADDIEX and ADDIWB exist, and addi executes.
- MC_ADDI_EN undefined: opcode 001000 is treated as illegal (illegal_op pulse, return to FETCH). The state encodings of the other states are unchanged.

## Structure
- Shared package/header `mips_ctrl_defs` holds:
  - the 4-bit state encodings
  - the opcode constants
  - the ALUOp codes (00/01/10)
  - the ALUSrcB and PCSrc select codes
- One natural sub-module, mc_output_decode: a purely combinational state-to-control-vector decode. The FSM module holds the state register and next-state logic.

## Test plan
- Reset asserted in MEMRD: state=0 (FETCH) immediately, RegWrite never pulses; release with mem_ready=1 -> IRWrite high on the first clock.
- lw (opcode 100011), mem_ready tied 1: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB (5 cycles); RegWrite=1 and MemtoReg=1 only in MEMWB.
- sw with mem_ready low for 3 cycles in MEMWR: MemWrite and mem_req held 4 cycles, then FETCH.
- beq with zero=1: pc_en=1 and PCSrc=01 in BRANCH. Repeat with zero=0: pc_en=0.
- R-type (000000): ALUOp=10 in EXEC, then RegDst=1 and RegWrite=1 in ALUWB.
- Opcode 111111: illegal_op pulses for one cycle and the FSM returns to FETCH. With MC_ADDI_EN undefined, opcode 001000 gives the same response.
